updown_game_ctrl: RTL and testbench



---
 rtl/updown_game_ctrl_if.sv | 30 +++
 rtl/updown_game_ctrl.sv | 110 +++++++++++
 tb/tb_updown_game_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/updown_game_ctrl_if.sv
// Signal bundle between the number-guessing sequencer and its RNG/display/input neighbours.
interface updown_game_ctrl_if #(
  parameter int unsigned TRY_W = 4
) ();
  logic [6:0]       rng_number;
  logic             start;
  logic [6:0]       guess;
  logic             guess_valid;
  logic             hint_up;
  logic             hint_down;
  logic             correct;
  logic             out_of_range;
  logic [TRY_W-1:0] tries;
  logic             playing;
  logic             game_over;
  logic             win;
  logic [6:0]       target_reveal;

  modport master (
    output rng_number, start, guess, guess_valid,
    input  hint_up, hint_down, correct, out_of_range, tries,
           playing, game_over, win, target_reveal
  );

  modport slave (
    input  rng_number, start, guess, guess_valid,
    output hint_up, hint_down, correct, out_of_range, tries,
           playing, game_over, win, target_reveal
  );
endinterface

// File: rtl/updown_game_ctrl.sv
// Up/down guessing game sequencer: captures a folded random target, judges guesses,
// and counts in-range attempts against a try limit.
//
// state | meaning
// IDLE  | waiting for start, guesses ignored
// PLAY  | game running, guesses judged
// WIN   | target guessed, outputs frozen
// LOSE  | try limit reached, outputs frozen
module updown_game_ctrl #(
  parameter int unsigned MAX_NUM   = 99,
  parameter int unsigned MAX_TRIES = 10,
  parameter int unsigned TRY_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  updown_game_ctrl_if.slave   gif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  localparam logic [6:0]       MAX_V   = 7'(MAX_NUM);
  localparam logic [6:0]       FOLD_V  = 7'(MAX_NUM + 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE = TRY_W'(1);

  state_e           state_q, state_d;
  logic [6:0]       target_q, target_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             hint_up_q, hint_up_d;
  logic             hint_down_q, hint_down_d;
  logic             correct_q, correct_d;
  logic             oor_q, oor_d;

  logic [TRY_W-1:0] tries_inc;
  logic [6:0]       rng_folded;

  assign tries_inc  = tries_q + TRY_ONE;
  // MAX_NUM >= 63 guarantees one subtraction maps 0..127 into 0..MAX_NUM.
  assign rng_folded = (gif.rng_number > MAX_V) ? (gif.rng_number - FOLD_V) : gif.rng_number;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      tries_q     <= '0;
      hint_up_q   <= 1'b0;
      hint_down_q <= 1'b0;
      correct_q   <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      tries_q     <= tries_d;
      hint_up_q   <= hint_up_d;
      hint_down_q <= hint_down_d;
      correct_q   <= correct_d;
      oor_q       <= oor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tries_d     = tries_q;
    hint_up_d   = hint_up_q;
    hint_down_d = hint_down_q;
    correct_d   = correct_q;
    oor_d       = 1'b0;

    // start beats a coincident guess in every state, including a running game.
    if (gif.start) begin
      state_d     = ST_PLAY;
      target_d    = rng_folded;
      tries_d     = '0;
      hint_up_d   = 1'b0;
      hint_down_d = 1'b0;
      correct_d   = 1'b0;
    end else if (state_q == ST_PLAY && gif.guess_valid) begin
      if (gif.guess > MAX_V) begin
        oor_d = 1'b1;
      end else begin
        tries_d     = tries_inc;
        hint_up_d   = (gif.guess < target_q);
        hint_down_d = (gif.guess > target_q);
        correct_d   = (gif.guess == target_q);
        if (gif.guess == target_q) begin
          state_d = ST_WIN;
        end else if (tries_inc == TRY_MAX) begin
          state_d = ST_LOSE;
        end
      end
    end
  end

  assign gif.hint_up       = hint_up_q;
  assign gif.hint_down     = hint_down_q;
  assign gif.correct       = correct_q;
  assign gif.out_of_range  = oor_q;
  assign gif.tries         = tries_q;
  assign gif.playing       = (state_q == ST_PLAY);
  assign gif.game_over     = (state_q == ST_WIN) || (state_q == ST_LOSE);
  assign gif.win           = (state_q == ST_WIN);
  assign gif.target_reveal = ((state_q == ST_WIN) || (state_q == ST_LOSE)) ? target_q : 7'd0;

endmodule

// File: tb/tb_updown_game_ctrl.sv
// Directed bench for updown_game_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_updown_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_game_ctrl_if #(.TRY_W(4)) gif ();

  updown_game_ctrl #(.MAX_NUM(99), .MAX_TRIES(10), .TRY_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif.slave)
  );

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       cor;
    logic       oor;
    logic [3:0] tries;
    logic       play;
    logic       over;
    logic       win;
    logic [6:0] rev;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       st;
    logic [6:0] rng;
    logic       gv;
    logic [6:0] g;
    obs_t       exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic obs_t mk(logic up, logic dn, logic cor, logic oor, int t,
                              logic play, logic over, logic win, int rev);
    obs_t o;
    o.up = up; o.dn = dn; o.cor = cor; o.oor = oor; o.tries = 4'(t);
    o.play = play; o.over = over; o.win = win; o.rev = 7'(rev);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.up = gif.hint_up; o.dn = gif.hint_down; o.cor = gif.correct;
    o.oor = gif.out_of_range; o.tries = gif.tries; o.play = gif.playing;
    o.over = gif.game_over; o.win = gif.win; o.rev = gif.target_reveal;
    return o;
  endfunction

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic apply(input logic rst, input logic st, input logic [6:0] rng,
                       input logic gv, input logic [6:0] g);
    reset = rst; gif.start = st; gif.rng_number = rng; gif.guess_valid = gv; gif.guess = g;
    @(negedge clk);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got up=%b dn=%b cor=%b oor=%b tries=%0d play=%b over=%b win=%b rev=%0d want up=%b dn=%b cor=%b oor=%b tries=%0d play=%b over=%b win=%b rev=%0d",
               name, act.up, act.dn, act.cor, act.oor, act.tries, act.play, act.over, act.win, act.rev,
               exp.up, exp.dn, exp.cor, exp.oor, exp.tries, exp.play, exp.over, exp.win, exp.rev);
    end
  endtask

  vec_t vecs[$];

  task automatic addv(input logic rst, input logic st, input int rng, input logic gv,
                      input int g, input obs_t exp);
    vec_t v;
    v.rst = rst; v.st = st; v.rng = 7'(rng); v.gv = gv; v.g = 7'(g); v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; gif.start = 1'b0; gif.rng_number = '0; gif.guess_valid = 1'b0; gif.guess = '0;

    //   rst st rng gv g       up dn cor oor t play over win rev
    addv(1, 0,   0, 0,   0, mk(0, 0, 0, 0, 0, 0, 0, 0,  0));  // reset state
    addv(0, 0,   0, 1,   5, mk(0, 0, 0, 0, 0, 0, 0, 0,  0));  // guess in IDLE ignored
    addv(0, 1,  42, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));
    addv(0, 0,   0, 1,  10, mk(1, 0, 0, 0, 1, 1, 0, 0,  0));
    addv(0, 0,   0, 1,  80, mk(0, 1, 0, 0, 2, 1, 0, 0,  0));
    addv(0, 0,   0, 0,   0, mk(0, 1, 0, 0, 2, 1, 0, 0,  0));  // hint holds
    addv(0, 0,   0, 1,  42, mk(0, 0, 1, 0, 3, 0, 1, 1, 42));
    addv(0, 0,   0, 1,  10, mk(0, 0, 1, 0, 3, 0, 1, 1, 42));  // frozen in WIN
    addv(0, 1, 120, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));  // fold 120 -> 20
    addv(0, 0,   0, 1,  20, mk(0, 0, 1, 0, 1, 0, 1, 1, 20));
    addv(0, 1,  99, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));  // 99 not folded
    addv(0, 0,   0, 1,  99, mk(0, 0, 1, 0, 1, 0, 1, 1, 99));
    addv(0, 1,  50, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));
    addv(0, 0,   0, 1, 100, mk(0, 0, 0, 1, 0, 1, 0, 0,  0));  // out of range
    addv(0, 0,   0, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));  // pulse ends
    addv(0, 0,   0, 1, 127, mk(0, 0, 0, 1, 0, 1, 0, 0,  0));
    addv(0, 0,   0, 1,  99, mk(0, 1, 0, 0, 1, 1, 0, 0,  0));  // 99 counted
    addv(0, 1, 127, 1,   5, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));  // start+guess: 127 -> 27
    addv(0, 0,   0, 1,  27, mk(0, 0, 1, 0, 1, 0, 1, 1, 27));
    addv(0, 1, 100, 0,   0, mk(0, 0, 0, 0, 0, 1, 0, 0,  0));  // fold 100 -> 0
    addv(0, 0,   0, 1,   0, mk(0, 0, 1, 0, 1, 0, 1, 1,  0));

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].rng, vecs[i].gv, vecs[i].g);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Lose after ten low guesses; an eleventh guess changes nothing.
    apply(0, 1, 50, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      apply(0, 0, 0, 1, 0);
      if (i < 10) check($sformatf("lose_try%0d", i), mk(1, 0, 0, 0, i, 1, 0, 0, 0));
    end
    check("lose_final", mk(1, 0, 0, 0, 10, 0, 1, 0, 50));
    apply(0, 0, 0, 1, 50);
    check("lose_frozen", mk(1, 0, 0, 0, 10, 0, 1, 0, 50));

    // Correct guess on the last allowed try wins.
    apply(0, 1, 7, 0, 0);
    for (int i = 1; i <= 9; i++) apply(0, 0, 0, 1, 0);
    check("try9", mk(1, 0, 0, 0, 9, 1, 0, 0, 0));
    apply(0, 0, 0, 1, 7);
    check("win_on_10th", mk(0, 0, 1, 0, 10, 0, 1, 1, 7));

    // Start aborting a running game drops the old count.
    apply(0, 1, 30, 0, 0);
    apply(0, 0, 0, 1, 60);
    apply(0, 0, 0, 1, 60);
    apply(0, 1, 10, 0, 0);
    check("restart", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

    // Reset mid-game with tries=5 and hint_down set.
    for (int i = 1; i <= 5; i++) apply(0, 0, 0, 1, 60);
    check("pre_reset", mk(0, 1, 0, 0, 5, 1, 0, 0, 0));
    apply(1, 0, 0, 1, 10);
    check("mid_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 0, 0, 1, 10);
    check("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 1, 42, 0, 0);
    check("reset_beats_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
